// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first, with direct seven-segment outputs.
// Optional ten's-complement subtract mode is built when BCD_SUB_EN is defined.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    start,
`ifdef BCD_SUB_EN
    input  logic                    sub,
`endif
    input  logic [4*DIGITS-1:0]     a_bcd,
    input  logic [4*DIGITS-1:0]     b_bcd,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum_bcd,
    output logic                    cout,
    output logic                    err,
    output logic [7*(DIGITS+1)-1:0] HEX
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_FIN
    } state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [4*DIGITS-1:0] sum_q;
    logic [IW-1:0]       idx_q;
    logic                c_q;
    logic                busy_q;
    logic                done_q;
    logic                cout_q;
    logic                err_q;

    logic                bad_d;
    logic [4*DIGITS-1:0] b_d;
    logic                c_d;
    logic [3:0]          a_dig;
    logic [3:0]          b_dig;
    logic [4:0]          t_d;
    logic                cnxt_d;
    logic [3:0]          dig_d;

    // Operand screening and B/carry-in preparation at acceptance time
    always_comb begin
        bad_d = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (a_bcd[4*k+:4] > 4'd9 || b_bcd[4*k+:4] > 4'd9)
                bad_d = 1'b1;
        end
`ifdef BCD_SUB_EN
        b_d = b_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (sub)
                b_d[4*k+:4] = 4'd9 - b_bcd[4*k+:4];
        end
        c_d = sub | cin;
`else
        b_d = b_bcd;
        c_d = cin;
`endif
    end

    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                a_dig = a_q[4*k+:4];
                b_dig = b_q[4*k+:4];
            end
        end
        t_d    = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, c_q};
        cnxt_d = (t_d > 5'd9);
        // Low nibble of t+6 is the decimal-corrected digit
        dig_d  = cnxt_d ? (t_d[3:0] + 4'd6) : t_d[3:0];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a_bcd;
                        b_q    <= b_d;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        idx_q  <= '0;
                        if (bad_d) begin
                            err_q   <= 1'b1;
                            c_q     <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            err_q   <= 1'b0;
                            c_q     <= c_d;
                            busy_q  <= 1'b1;
                            state_q <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (idx_q == IW'(k))
                            sum_q[4*k+:4] <= dig_d;
                    end
                    c_q   <= cnxt_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST)
                        state_q <= S_FIN;
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cout_q  <= c_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        HEX = '1;
        if (!err_q) begin
            for (int k = 0; k < DIGITS; k++)
                HEX[7*k+:7] = seg7(sum_q[4*k+:4]);
            HEX[7*DIGITS+:7] = seg7({3'b000, cout_q});
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_bcd = sum_q;
    assign cout    = cout_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed scoreboard bench for bcd_serial_adder (DIGITS=4).
// Subtract cases are included when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

    localparam int D  = 4;
    localparam int W  = 4 * D;
    localparam int HW = 7 * (D + 1);

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b1;
    logic          start    = 1'b0;
    logic          cin      = 1'b0;
    logic [W-1:0]  a_bcd    = '0;
    logic [W-1:0]  b_bcd    = '0;
`ifdef BCD_SUB_EN
    logic          sub      = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic          cout;
    logic          err;
    logic [W-1:0]  sum_bcd;
    logic [HW-1:0] HEX;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
`ifdef BCD_SUB_EN
        .sub      (sub),
`endif
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum_bcd  (sum_bcd),
        .cout     (cout),
        .err      (err),
        .HEX      (HEX)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k+:4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int k = 0; k < D; k++) begin
            r[4*k+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic b = 1'b0;
        for (int k = 0; k < D; k++) if (v[4*k+:4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [HW-1:0] hex_exp(input exp_t e);
        logic [HW-1:0] h = '1;
        if (!e.err) begin
            for (int k = 0; k < D; k++) h[7*k+:7] = seg(int'(e.sum[4*k+:4]));
            h[7*D+:7] = seg(int'(e.cout));
        end
        return h;
    endfunction

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        exp_t e;
        int r;
        if (has_bad(a) || has_bad(b)) begin
            e.sum = '0; e.cout = 1'b0; e.err = 1'b1;
        end else begin
            if (s) r = bcd2int(a) + pow10(D) - bcd2int(b);
            else   r = bcd2int(a) + bcd2int(b) + int'(c);
            e.cout = (r >= pow10(D));
            e.sum  = int2bcd(r % pow10(D));
            e.err  = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s.sb: got empty scoreboard expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".sum"},  64'(sum_bcd), 64'(e.sum));
        chk({tag, ".cout"}, 64'(cout),    64'(e.cout));
        chk({tag, ".err"},  64'(err),     64'(e.err));
        chk({tag, ".hex"},  64'(HEX),     64'(hex_exp(e)));
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        a_bcd = a;
        b_bcd = b;
        cin   = c;
`ifdef BCD_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s, input string tag);
        int   lat = 0;
        logic bad_busy = 1'b0;
        logic e_err = has_bad(a) || has_bad(b);
        int   exp_lat = e_err ? 1 : D + 1;
        push_exp(a, b, c, s);
        drive(a, b, c, s);
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        a_bcd = '1;
        b_bcd = '1;
        chk({tag, ".busy0"}, 64'(busy), 64'(!e_err));
        while (done !== 1'b1 && lat < 40) begin
            @(posedge CLOCK_50); #1;
            lat++;
            if (lat < exp_lat && busy !== !e_err) bad_busy = 1'b1;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busyrun"}, 64'(bad_busy), 64'(0));
        chk({tag, ".busyend"}, 64'(busy), 64'(0));
        check_done(tag);
        @(posedge CLOCK_50); #1;
        chk({tag, ".donefall"}, 64'(done), 64'(0));
    endtask

    initial begin
        exp_t z;
        int   dones;
        int   lat1;
        int   lat2;
        logic saw;
        z.sum = '0; z.cout = 1'b0; z.err = 1'b0;

        #1 resetn = 1'b0;
        #2;
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.sum",  64'(sum_bcd), 64'(0));
        chk("rst.cout", 64'(cout), 64'(0));
        chk("rst.err",  64'(err), 64'(0));
        chk("rst.hex",  64'(HEX), 64'(hex_exp(z)));
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;

        op(16'h0042, 16'h0058, 1'b0, 1'b0, "add42_58");
        op(16'h9999, 16'h0001, 1'b0, 1'b0, "add9999_1");
        op(16'h9999, 16'h0000, 1'b1, 1'b0, "add9999_cin");
        op(16'h1234, 16'h0765, 1'b1, 1'b0, "add1234_765c");
        op(16'h00A0, 16'h0000, 1'b0, 1'b0, "errA");
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("errhold.err", 64'(err), 64'(1));
        chk("errhold.hex", 64'(HEX), 64'({HW{1'b1}}));
        op(16'h0005, 16'h0004, 1'b0, 1'b0, "errclr");
        op(16'h0000, 16'hF000, 1'b0, 1'b0, "errB");
        op(16'h5050, 16'h4949, 1'b1, 1'b0, "add5050_4949c");

        // second start mid-operation must be ignored
        push_exp(16'h1234, 16'h4321, 1'b0, 1'b0);
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        a_bcd = 16'h8888;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        dones = 0;
        lat1  = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    lat1 = i + 2;
                    check_done("ignore");
                end
            end
            @(posedge CLOCK_50); #1;
        end
        chk("ignore.dones", 64'(dones), 64'(1));
        chk("ignore.lat",   64'(lat1),  64'(D + 1));

        // start held high: back-to-back operations
        push_exp(16'h0001, 16'h0001, 1'b0, 1'b0);
        push_exp(16'h0001, 16'h0001, 1'b0, 1'b0);
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        @(posedge CLOCK_50); #1;
        dones = 0;
        lat1  = 0;
        lat2  = 0;
        for (int l = 1; l <= 11; l++) begin
            @(posedge CLOCK_50); #1;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) lat1 = l;
                else            lat2 = l;
                check_done("held");
            end
        end
        start = 1'b0;
        chk("held.dones", 64'(dones), 64'(2));
        chk("held.lat1",  64'(lat1),  64'(D + 1));
        chk("held.lat2",  64'(lat2),  64'(2 * D + 3));
        repeat (8) @(posedge CLOCK_50);
        #1;
        chk("held.idle", 64'(busy), 64'(0));

        // reset in the middle of ADD
        drive(16'h5678, 16'h1111, 1'b0, 1'b0);
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        resetn = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.done", 64'(done), 64'(0));
        chk("abort.sum",  64'(sum_bcd), 64'(0));
        chk("abort.cout", 64'(cout), 64'(0));
        chk("abort.err",  64'(err), 64'(0));
        chk("abort.hex",  64'(HEX), 64'(hex_exp(z)));
        saw = 1'b0;
        repeat (3) begin
            @(posedge CLOCK_50); #1;
            if (done !== 1'b0) saw = 1'b1;
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (6) begin
            @(posedge CLOCK_50); #1;
            if (done !== 1'b0) saw = 1'b1;
        end
        chk("abort.nodone", 64'(saw), 64'(0));
        op(16'h0001, 16'h0002, 1'b0, 1'b0, "post_rst");

`ifdef BCD_SUB_EN
        op(16'h0100, 16'h0058, 1'b0, 1'b1, "sub100_58");
        op(16'h0058, 16'h0100, 1'b0, 1'b1, "sub58_100");
        op(16'h4321, 16'h4321, 1'b0, 1'b1, "subeq");
`endif

        chk("sb.empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
